// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control sequencer.
package ctrl_pkg;

  // One state per datapath phase; FAULT is terminal until reset.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_I,
    ST_EXEC_R,
    ST_MEM_ADR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_ALU,
    ST_WB_MEM,
    ST_BRANCH,
    ST_FAULT
  } state_t;

  // Opcode field values.
  localparam logic [1:0] OP_ALUI = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_REG  = 2'b10;
  localparam logic [1:0] OP_ALT  = 2'b11;

  // ALU B-operand mux.
  localparam logic [1:0] ALUSRC_B_RS2  = 2'b00;
  localparam logic [1:0] ALUSRC_B_IMM  = 2'b01;
  localparam logic [1:0] ALUSRC_B_FOUR = 2'b10;

  // Writeback mux.
  localparam logic [1:0] REGSRC_ALUI = 2'b00;
  localparam logic [1:0] REGSRC_MEM  = 2'b01;
  localparam logic [1:0] REGSRC_REG  = 2'b10;
  localparam logic [1:0] REGSRC_ALT  = 2'b11;

  // Immediate formats.
  localparam logic [1:0] IMM_I   = 2'b00;
  localparam logic [1:0] IMM_S   = 2'b01;
  localparam logic [1:0] IMM_R   = 2'b10;
  localparam logic [1:0] IMM_ALT = 2'b11;

  // Wait counter width; covers timeouts up to 1023 cycles.
  localparam int WAIT_W = 10;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been left waiting and flags the
// cycle on which one more idle cycle would reach the timeout.
module mem_wait_timer
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  // Clear has priority; otherwise advance once per unanswered cycle.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_en_i) begin
      count_d = count_q + WAIT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // This unanswered cycle is the MEM_TIMEOUT-th one.
  assign expired_o = count_en_i && (count_q == LAST_WAIT);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer: walks the shared datapath through fetch, decode,
// execute, memory and writeback, one instruction at a time.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int RET_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic [1:0]       op,
  input  logic             funct5,
  input  logic             funct0,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memw,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             regw,
  output logic             alusrc_a,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       immsrc,
  output logic [1:0]       regsrc,
  output logic             alu_op,
  output logic             busy,
  output logic             fault,
  output logic [RET_W-1:0] retired
);

  state_t           state_q;
  state_t           state_d;
  logic [RET_W-1:0] retired_q;
  logic [RET_W-1:0] retired_d;
  logic             retire;
  logic             timer_count;
  logic             timer_expired;

  // Count only while a request is open and unanswered; any other cycle
  // (including the handshake cycle) leaves the counter at zero for the
  // next wait state.
  assign timer_count = is_mem_wait(state_q) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!timer_count),
    .count_en_i(timer_count),
    .expired_o (timer_expired)
  );

  // Next-state and control decode; outputs depend on state_q only, except
  // the fetch-completion and branch pc_write pulses.
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    memw      = 1'b0;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    regw      = 1'b0;
    alusrc_a  = 1'b0;
    alusrc_b  = ALUSRC_B_RS2;
    immsrc    = IMM_I;
    regsrc    = REGSRC_ALUI;
    alu_op    = 1'b0;
    fault     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!halt) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req  = 1'b1;
        alusrc_b = ALUSRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        case (op)
          OP_ALUI: state_d = ST_EXEC_I;
          OP_MEM:  state_d = ST_MEM_ADR;
          OP_REG:  state_d = funct0 ? ST_BRANCH : ST_EXEC_R;
          default: state_d = ST_EXEC_R;
        endcase
      end
      ST_EXEC_I: begin
        alusrc_a = 1'b1;
        alusrc_b = ALUSRC_B_IMM;
        immsrc   = IMM_I;
        state_d  = ST_WB_ALU;
      end
      ST_EXEC_R: begin
        alusrc_a = 1'b1;
        alusrc_b = ALUSRC_B_RS2;
        alu_op   = 1'b1;
        immsrc   = (op == OP_ALT) ? IMM_ALT : IMM_R;
        state_d  = ST_WB_ALU;
      end
      ST_MEM_ADR: begin
        alusrc_a = 1'b1;
        alusrc_b = ALUSRC_B_IMM;
        immsrc   = IMM_S;
        state_d  = funct5 ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = ST_WB_MEM;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        memw    = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_WB_ALU: begin
        regw   = 1'b1;
        regsrc = op[1] ? (op[0] ? REGSRC_ALT : REGSRC_REG) : REGSRC_ALUI;
        retire = 1'b1;
      end
      ST_WB_MEM: begin
        regw   = 1'b1;
        regsrc = REGSRC_MEM;
        retire = 1'b1;
      end
      ST_BRANCH: begin
        alusrc_a = 1'b1;
        alusrc_b = ALUSRC_B_RS2;
        alu_op   = 1'b1;
        pc_src   = 1'b1;
        pc_write = zero;
        retire   = 1'b1;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Retirement is the instruction boundary where halt is honoured.
    if (retire) begin
      retired_d = retired_q + RET_W'(1);
      state_d   = halt ? ST_IDLE : ST_FETCH;
    end
  end

  // State and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed vector table,
// hand-written multi-cycle sequences and randomized instruction streams.
module tb_multicycle_control_fsm;

  localparam int RET_W = 16;
  localparam int TMO   = 4;

  logic             clk;
  logic             rst_n;
  logic             halt;
  logic [1:0]       op;
  logic             funct5;
  logic             funct0;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             memw;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             regw;
  logic             alusrc_a;
  logic [1:0]       alusrc_b;
  logic [1:0]       immsrc;
  logic [1:0]       regsrc;
  logic             alu_op;
  logic             busy;
  logic             fault;
  logic [RET_W-1:0] retired;
  logic [16:0]      obs;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm #(
    .RET_W      (RET_W),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .halt     (halt),
    .op       (op),
    .funct5   (funct5),
    .funct0   (funct0),
    .zero     (zero),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .memw     (memw),
    .adr_src  (adr_src),
    .ir_write (ir_write),
    .pc_write (pc_write),
    .pc_src   (pc_src),
    .regw     (regw),
    .alusrc_a (alusrc_a),
    .alusrc_b (alusrc_b),
    .immsrc   (immsrc),
    .regsrc   (regsrc),
    .alu_op   (alu_op),
    .busy     (busy),
    .fault    (fault),
    .retired  (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {mem_req, memw, adr_src, ir_write, pc_write, pc_src, regw, alusrc_a,
                alusrc_b, immsrc, regsrc, alu_op, busy, fault};

  // Expected control words, one per phase, written from the phase table.
  function automatic logic [16:0] mk(input logic mreq, mw, adr, irw, pcw, pcs, rw, asa,
                                     input logic [1:0] asb, imm, rs,
                                     input logic aop, bsy, flt);
    return {mreq, mw, adr, irw, pcw, pcs, rw, asa, asb, imm, rs, aop, bsy, flt};
  endfunction

  localparam logic [16:0] W_IDLE  = 17'd0;
  localparam logic [16:0] W_FAULT = 17'd1;

  function automatic logic [16:0] f_fetch(input logic done);
    return mk(1, 0, 0, done, done, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [16:0] f_dec();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [16:0] f_exi();
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [16:0] f_exr(input logic [1:0] o);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, (o == 2'b11) ? 2'b11 : 2'b10, 2'b00, 1, 1, 0);
  endfunction
  function automatic logic [16:0] f_madr();
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b01, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [16:0] f_mrd();
    return mk(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [16:0] f_mwr();
    return mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [16:0] f_wba(input logic [1:0] o);
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, o[1] ? {1'b1, o[0]} : 2'b00, 0, 1, 0);
  endfunction
  function automatic logic [16:0] f_wbm();
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0);
  endfunction
  function automatic logic [16:0] f_br(input logic z);
    return mk(0, 0, 0, 0, z, 1, 0, 1, 2'b00, 2'b00, 2'b00, 1, 1, 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare the control word mid-cycle.
  task automatic cyc(input string name, input logic rdy, input logic hlt, input logic [16:0] exp);
    mem_ready = rdy;
    halt      = hlt;
    @(negedge clk);
    check(name, {47'd0, obs}, {47'd0, exp});
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: whole instructions with zero-wait memory.
  typedef struct {
    logic [1:0] op;
    logic       f5;
    logic       f0;
    logic       z;
    int         cycles;
    logic       regw;
    logic [1:0] regsrc;
    logic       pcw;
  } vec_t;

  // Per-cycle plan for the randomized reference model.
  typedef struct {
    logic        rdy;
    logic        hlt;
    logic [16:0] exp;
  } cyc_t;

  vec_t             vecs[9];
  cyc_t             plan[$];
  logic [RET_W-1:0] exp_ret;

  task automatic add(input logic r, input logic h, input logic [16:0] e);
    cyc_t c;
    c.rdy = r;
    c.hlt = h;
    c.exp = e;
    plan.push_back(c);
  endtask

  initial begin
    int         n;
    logic       saw_rw;
    logic [1:0] rs;
    logic       saw_pcw;
    bit         done;
    bit         pre_idle;
    int         d;
    logic [1:0] rop;
    logic       rf5;
    logic       rf0;
    logic       rz;
    logic       rh;

    vecs[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 4, 1'b1, 2'b00, 1'b0};
    vecs[1] = '{2'b00, 1'b0, 1'b0, 1'b0, 4, 1'b1, 2'b00, 1'b0};
    vecs[2] = '{2'b01, 1'b1, 1'b0, 1'b0, 5, 1'b1, 2'b01, 1'b0};
    vecs[3] = '{2'b01, 1'b0, 1'b0, 1'b0, 4, 1'b0, 2'b00, 1'b0};
    vecs[4] = '{2'b10, 1'b0, 1'b1, 1'b1, 3, 1'b0, 2'b00, 1'b1};
    vecs[5] = '{2'b10, 1'b0, 1'b1, 1'b0, 3, 1'b0, 2'b00, 1'b0};
    vecs[6] = '{2'b10, 1'b0, 1'b0, 1'b0, 4, 1'b1, 2'b10, 1'b0};
    vecs[7] = '{2'b11, 1'b0, 1'b0, 1'b0, 4, 1'b1, 2'b11, 1'b0};
    vecs[8] = '{2'b11, 1'b0, 1'b1, 1'b1, 4, 1'b1, 2'b11, 1'b0};

    rst_n = 1'b1; halt = 1'b0; op = 2'b00; funct5 = 1'b0; funct0 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset_ctl", {47'd0, obs}, 64'd0);
    check("reset_retired", {48'd0, retired}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = '0;
    cyc("idle0", 1'b1, 1'b0, W_IDLE);

    // Vector table.
    for (int i = 0; i < 9; i++) begin
      op = vecs[i].op; funct5 = vecs[i].f5; funct0 = vecs[i].f0; zero = vecs[i].z;
      mem_ready = 1'b1; halt = 1'b0;
      n = 0; saw_rw = 1'b0; rs = 2'b00; saw_pcw = 1'b0; done = 1'b0;
      while (!done && n < 20) begin
        @(negedge clk);
        n++;
        if (regw) begin saw_rw = 1'b1; rs = regsrc; end
        if (pc_write && !ir_write) saw_pcw = 1'b1;
        @(posedge clk);
        #1;
        if (retired != exp_ret) done = 1'b1;
      end
      exp_ret++;
      $display("vec %0d op=%b f5=%b f0=%b z=%b cycles=%0d", i, vecs[i].op, vecs[i].f5,
               vecs[i].f0, vecs[i].z, n);
      check($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].cycles));
      check($sformatf("vec%0d_retired", i), {48'd0, retired}, {48'd0, exp_ret});
      check($sformatf("vec%0d_regw", i), {63'd0, saw_rw}, {63'd0, vecs[i].regw});
      check($sformatf("vec%0d_regsrc", i), {62'd0, rs}, {62'd0, vecs[i].regsrc});
      check($sformatf("vec%0d_branch_pcw", i), {63'd0, saw_pcw}, {63'd0, vecs[i].pcw});
    end

    // Load with three wait cycles in MEM_RD: 8 cycles total.
    op = 2'b01; funct5 = 1'b1; funct0 = 1'b0;
    cyc("ld_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("ld_dec", 1'b0, 1'b0, f_dec());
    cyc("ld_madr", 1'b0, 1'b0, f_madr());
    for (int i = 0; i < 3; i++) cyc("ld_rd_wait", 1'b0, 1'b0, f_mrd());
    cyc("ld_rd_done", 1'b1, 1'b0, f_mrd());
    cyc("ld_wbm", 1'b0, 1'b0, f_wbm());
    exp_ret++;
    check("ld_retired", {48'd0, retired}, {48'd0, exp_ret});
    $display("seq load_delayed retired=%0d", retired);

    // halt raised during EXEC_R: instruction completes, then IDLE.
    op = 2'b10; funct0 = 1'b0; funct5 = 1'b0;
    cyc("hr_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("hr_dec", 1'b0, 1'b0, f_dec());
    cyc("hr_exr", 1'b0, 1'b1, f_exr(2'b10));
    cyc("hr_wba", 1'b0, 1'b1, f_wba(2'b10));
    exp_ret++;
    check("hr_retired", {48'd0, retired}, {48'd0, exp_ret});
    cyc("hr_idle_hold", 1'b1, 1'b1, W_IDLE);
    cyc("hr_idle_go", 1'b0, 1'b0, W_IDLE);
    op = 2'b00;
    cyc("hr_fetch_next", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("hr_dec2", 1'b0, 1'b0, f_dec());
    cyc("hr_exi", 1'b0, 1'b0, f_exi());
    cyc("hr_wba2", 1'b0, 1'b0, f_wba(2'b00));
    exp_ret++;
    $display("seq halt_mid_instr retired=%0d", retired);

    // mem_ready on the last allowed wait cycle wins over the timeout.
    for (int i = 0; i < TMO - 1; i++) cyc("tmo_wait", 1'b0, 1'b0, f_fetch(1'b0));
    cyc("tmo_late_ready", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("tmo_nofault", 1'b0, 1'b0, f_dec());
    cyc("tmo_exi", 1'b0, 1'b0, f_exi());
    cyc("tmo_wba", 1'b0, 1'b0, f_wba(2'b00));
    exp_ret++;
    check("tmo_retired", {48'd0, retired}, {48'd0, exp_ret});

    // No answer for MEM_TIMEOUT cycles: FAULT, sticky.
    for (int i = 0; i < TMO; i++) cyc("tmo_wait2", 1'b0, 1'b0, f_fetch(1'b0));
    cyc("fault_entry", 1'b0, 1'b0, W_FAULT);
    cyc("fault_sticky", 1'b1, 1'b0, W_FAULT);
    cyc("fault_sticky2", 1'b0, 1'b1, W_FAULT);
    $display("seq timeout fault=%b", fault);

    // Reset clears FAULT.
    rst_n = 1'b0;
    #1;
    check("rst_from_fault", {47'd0, obs}, 64'd0);
    check("rst_from_fault_ret", {48'd0, retired}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = '0;
    op = 2'b00;
    cyc("e_idle", 1'b0, 1'b0, W_IDLE);
    cyc("e_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("e_dec", 1'b0, 1'b0, f_dec());
    cyc("e_exi", 1'b0, 1'b0, f_exi());
    cyc("e_wba", 1'b0, 1'b0, f_wba(2'b00));
    exp_ret++;
    check("e_retired", {48'd0, retired}, {48'd0, exp_ret});

    // Asynchronous reset in the middle of a store wait.
    op = 2'b01; funct5 = 1'b0;
    cyc("st_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("st_dec", 1'b0, 1'b0, f_dec());
    cyc("st_madr", 1'b0, 1'b0, f_madr());
    mem_ready = 1'b0;
    #2;
    check("st_mwr_pre", {47'd0, obs}, {47'd0, f_mwr()});
    rst_n = 1'b0;
    #1;
    check("st_async_drop", {47'd0, obs}, 64'd0);
    check("st_async_ret", {48'd0, retired}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    $display("seq async_reset_mid_store retired=%0d", retired);

    // Randomized instruction stream against the phase-list model.
    exp_ret  = '0;
    pre_idle = 1'b1;
    for (int k = 0; k < 60; k++) begin
      rop = 2'($urandom_range(0, 3));
      rf5 = 1'($urandom); rf0 = 1'($urandom); rz = 1'($urandom);
      rh  = ($urandom_range(0, 3) == 0);
      plan.delete();
      if (pre_idle) add(1'($urandom), 1'b0, W_IDLE);
      d = $urandom_range(0, TMO - 1);
      for (int j = 0; j < d; j++) add(1'b0, 1'($urandom), f_fetch(1'b0));
      add(1'b1, 1'($urandom), f_fetch(1'b1));
      add(1'($urandom), 1'($urandom), f_dec());
      case (rop)
        2'b00: begin
          add(1'($urandom), 1'($urandom), f_exi());
          add(1'($urandom), rh, f_wba(rop));
        end
        2'b01: begin
          add(1'($urandom), 1'($urandom), f_madr());
          d = $urandom_range(0, TMO - 1);
          if (rf5) begin
            for (int j = 0; j < d; j++) add(1'b0, 1'($urandom), f_mrd());
            add(1'b1, 1'($urandom), f_mrd());
            add(1'($urandom), rh, f_wbm());
          end else begin
            for (int j = 0; j < d; j++) add(1'b0, 1'($urandom), f_mwr());
            add(1'b1, rh, f_mwr());
          end
        end
        2'b10: begin
          if (rf0) begin
            add(1'($urandom), rh, f_br(rz));
          end else begin
            add(1'($urandom), 1'($urandom), f_exr(rop));
            add(1'($urandom), rh, f_wba(rop));
          end
        end
        default: begin
          add(1'($urandom), 1'($urandom), f_exr(rop));
          add(1'($urandom), rh, f_wba(rop));
        end
      endcase
      op = rop; funct5 = rf5; funct0 = rf0; zero = rz;
      foreach (plan[j]) cyc($sformatf("rnd%0d_c%0d", k, j), plan[j].rdy, plan[j].hlt, plan[j].exp);
      exp_ret++;
      check($sformatf("rnd%0d_retired", k), {48'd0, retired}, {48'd0, exp_ret});
      $display("txn %0d op=%b f5=%b f0=%b z=%b halt_at_retire=%b cycles=%0d",
               k, rop, rf5, rf0, rz, rh, plan.size());
      pre_idle = rh;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle sequencer for the 2-bit-op core. It steps one shared ALU/memory datapath through the fetch, decode, execute, memory and writeback phases, one instruction at a time.
- Sits beside the datapath and replaces per-instruction combinational control with per-state control pulses.
- Handshakes with a variable-latency unified memory and counts retired instructions.

Parameters:
RET_W, 16, width of retired-instruction counter.
MEM_TIMEOUT, 255, max cycles waiting for mem_ready before FAULT (1..2^10-1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
halt  in  1  hold core in IDLE at instruction boundary.
op  in  2  IR opcode field, valid from DECODE onward.
funct5  in  1  IR bit; for op=01, 1 = load, 0 = store.
funct0  in  1  IR bit; for op=10, 1 = branch, 0 = register ALU.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory request, held until mem_ready.
memw  out  1  write qualifier for mem_req.
adr_src  out  1  0 = PC address, 1 = ALU-result register.
ir_write  out  1  load instruction register.
pc_write  out  1  load PC.
pc_src  out  1  0 = PC+4, 1 = branch target.
regw  out  1  register-file write.
alusrc_a  out  1  0 = PC, 1 = rs1.
alusrc_b  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
immsrc  out  2  immediate format.
regsrc  out  2  writeback mux: 00 ALU-imm, 01 memory, 10 reg ALU, 11 alt reg ALU.
alu_op  out  1  0 = add, 1 = funct-decoded/compare.
busy  out  1  not IDLE and not FAULT.
fault  out  1  sticky memory-timeout flag.
retired  out  RET_W  retired-instruction count.

Behaviour:
- Reset (async, any state, mid-handshake included):
  - state = IDLE, retired = 0, fault = 0, wait counter = 0.
  - All control outputs are 0 immediately; mem_req drops without waiting for a clock edge.
- Outputs are Moore, decoded from the state register only, except the pc_write/ir_write pulses noted below.
- States and outputs (unlisted outputs are 0):
  - IDLE: if halt = 0, go to FETCH.
  - FETCH:
    - Drives mem_req = 1, adr_src = 0, alusrc_a = 0, alusrc_b = 10.
    - On the mem_ready cycle it also drives ir_write = 1 and pc_write = 1 (pc_src = 0), then goes to DECODE. Without mem_ready it stays.
  - DECODE, branch on op:
    - 00 -> EXEC_I
    - 01 -> MEM_ADR
    - 10 with funct0 = 1 -> BRANCH
    - 10 with funct0 = 0 -> EXEC_R
    - 11 -> EXEC_R
  - EXEC_I: alusrc_a = 1, alusrc_b = 01, immsrc = 00, alu_op = 0. Goes to WB_ALU.
  - EXEC_R: alusrc_a = 1, alusrc_b = 00, alu_op = 1, immsrc = (op = 11 ? 11 : 10). Goes to WB_ALU.
  - MEM_ADR: alusrc_a = 1, alusrc_b = 01, immsrc = 01. Goes to MEM_RD if funct5 = 1, else MEM_WR.
  - MEM_RD: mem_req = 1, adr_src = 1. On mem_ready goes to WB_MEM.
  - MEM_WR: mem_req = 1, memw = 1, adr_src = 1. On mem_ready the instruction retires.
  - WB_ALU: regw = 1, regsrc = {op = 10 or 11 ? 1x : 00}, with low bit = op[0] for register ops. The instruction retires.
  - WB_MEM: regw = 1, regsrc = 01. The instruction retires.
  - BRANCH: alusrc_a = 1, alusrc_b = 00, alu_op = 1, pc_src = 1, pc_write = zero. The instruction retires.
  - Retire: retired increments by 1 (wraps at 2^RET_W), then the next state is IDLE if halt = 1, else FETCH.
  - FAULT: all control outputs 0, fault = 1. Stays here until rst_n.
- Memory handshake:
  - mem_req, memw and adr_src are stable from the state's entry until the mem_ready cycle.
  - mem_ready while mem_req = 0 is ignored.
  - mem_ready in the first cycle of a wait state means zero wait: the wait state lasts 1 cycle.
- Timeout:
  - The wait counter clears on entry to FETCH, MEM_RD or MEM_WR and increments each cycle mem_ready = 0.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
  - mem_ready arriving on that same cycle wins; no fault is raised.
- halt is sampled only at IDLE and at retire. Assertion mid-instruction completes the current instruction first.
- Instruction latency (zero-wait memory): ALU 4 cycles, load 5, store 4, branch 3.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum
  - OP_ALUI/OP_MEM/OP_REG/OP_ALT localparams
  - ALUSRC_B_* localparams
  - REGSRC_* localparams
  - IMM_* localparams
- Sub-module mem_wait_timer (clear, count_en, expired) holds the timeout counter.

Test Plan:
- Reset with halt = 0, op = 00, mem_ready always 1 -> FETCH/DECODE/EXEC_I/WB_ALU; regw = 1 only in WB_ALU; retired = 1 after 4 cycles, 2 after 8.
- op = 01, funct5 = 1, mem_ready delayed 3 cycles in MEM_RD -> mem_req/adr_src = 1 held for 4 cycles, then WB_MEM with regsrc = 01; total 8 cycles.
- op = 10, funct0 = 1, zero = 1 then zero = 0 -> BRANCH pc_write = 1, pc_src = 1 first; pc_write = 0 second; each 3 cycles.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH -> FAULT entered after 4 wait cycles, fault = 1, mem_req = 0; mem_ready on the 4th cycle instead -> no fault.
- halt = 1 asserted during EXEC_R -> WB_ALU completes, retired increments, IDLE with busy = 0; halt = 0 -> FETCH next cycle.
- rst_n low mid-MEM_WR -> mem_req and memw drop asynchronously, retired = 0; release -> IDLE.
